// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID->EX pipeline register with MEM/WB operand forwarding and load-use stall.
// Optional PerfBubbleCnt/PerfFlushCnt counters enabled by ID_EX_PERF_CNT_EN.
module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int ALUC_W = 5,
    parameter logic [ALUC_W-1:0] ALU_ADD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   RegReadData1,
    input  logic [XLEN-1:0]   RegReadData2,
    input  logic [RA_W-1:0]   Rs1,
    input  logic [RA_W-1:0]   Rs2,
    input  logic [RA_W-1:0]   Rd,
    input  logic [XLEN-1:0]   ImmD,
    input  logic [XLEN-1:0]   PCD,
    input  logic              AluSrc1D,
    input  logic [1:0]        AluSrc2D,
    input  logic [ALUC_W-1:0] AluContrlD,
    input  logic              RegWriteD,
    input  logic              MemToRegD,
    input  logic              MemWriteD,
    input  logic              ex_stall,
    input  logic              flush,
    input  logic [RA_W-1:0]   MemRd,
    input  logic              MemRegWrite,
    input  logic [XLEN-1:0]   MemAluOut,
    input  logic [RA_W-1:0]   WbRd,
    input  logic              WbRegWrite,
    input  logic [XLEN-1:0]   WbData,
    output logic [XLEN-1:0]   Operand1,
    output logic [XLEN-1:0]   Operand2,
    output logic [ALUC_W-1:0] AluContrl,
    output logic [XLEN-1:0]   StoreDataE,
    output logic              ex_valid,
    output logic [RA_W-1:0]   RdE,
    output logic              RegWriteE,
    output logic              MemToRegE,
    output logic              MemWriteE,
    output logic [XLEN-1:0]   PCE,
    output logic              id_stall
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       PerfBubbleCnt,
    output logic [31:0]       PerfFlushCnt
`endif
);
    typedef struct packed {
        logic              valid;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [RA_W-1:0]   rd;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic              src1;
        logic [1:0]        src2;
        logic [ALUC_W-1:0] aluc;
        logic              regwrite;
        logic              memtoreg;
        logic              memwrite;
    } ex_t;
    ex_t q, d, bub, load;
    logic [XLEN-1:0] fwd1, fwd2;
    always_comb begin
        bub = '0;
        bub.aluc = ALU_ADD;
        load = '{id_valid, Rs1, Rs2, Rd, RegReadData1, RegReadData2, ImmD, PCD,
                 AluSrc1D, AluSrc2D, AluContrlD, RegWriteD, MemToRegD, MemWriteD};
        d = ex_stall ? q : (flush || id_stall) ? bub : load;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= bub;
        else q <= d;
    // x0 is never forwarded; MEM is younger than WB so it wins
    assign fwd1 = (q.rs1 != '0 && MemRegWrite && MemRd == q.rs1) ? MemAluOut :
                  (q.rs1 != '0 && WbRegWrite && WbRd == q.rs1) ? WbData : q.rd1;
    assign fwd2 = (q.rs2 != '0 && MemRegWrite && MemRd == q.rs2) ? MemAluOut :
                  (q.rs2 != '0 && WbRegWrite && WbRd == q.rs2) ? WbData : q.rd2;
    assign Operand1 = q.src1 ? q.pc : fwd1;
    assign Operand2 = q.src2 == 2'd0 ? fwd2 : q.src2 == 2'd2 ? XLEN'(4) : q.imm;
    assign StoreDataE = fwd2;
    assign AluContrl = q.aluc;
    assign ex_valid = q.valid;
    assign RdE = q.rd;
    assign RegWriteE = q.regwrite;
    assign MemToRegE = q.memtoreg;
    assign MemWriteE = q.memwrite;
    assign PCE = q.pc;
    assign id_stall = q.valid && q.memtoreg && q.rd != '0 && id_valid &&
                      (q.rd == Rs1 || q.rd == Rs2) && !flush && !ex_stall;
`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            PerfBubbleCnt <= '0;
            PerfFlushCnt <= '0;
        end else begin
            PerfBubbleCnt <= PerfBubbleCnt + 32'(id_stall);
            PerfFlushCnt <= PerfFlushCnt + 32'(!ex_stall && flush && id_valid);
        end
`endif
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID→EX pipeline register plus EX-side operand forwarding for the RV32I core.
- Captures decoded fields each cycle and resolves RAW hazards by forwarding from MEM/WB; detects load-use hazards and inserts bubbles.
- Drives Operand1/Operand2/AluContrl straight into the ALU; honours downstream stall (cache miss) and branch flush.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width
ALUC_W, 5, ALU control code width (matches ALU encoding, incl. ADD/LUI codes from shared parameter header)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode slot holds a real instruction
RegReadData1 / RegReadData2  in  XLEN  register file read data
Rs1 / Rs2 / Rd  in  RA_W  source/dest register numbers
ImmD  in  XLEN  sign-extended immediate
PCD  in  XLEN  instruction PC
AluSrc1D  in  1  0=rs1, 1=PC
AluSrc2D  in  2  0=rs2, 1=imm, 2=constant 4, 3=reserved (treated as imm)
AluContrlD  in  ALUC_W  ALU operation code
RegWriteD / MemToRegD / MemWriteD  in  1  decoded control
ex_stall  in  1  downstream (MEM/cache) cannot accept; hold EX
flush  in  1  branch/jump resolved taken; ID instruction is wrong-path
MemRd  in  RA_W; MemRegWrite  in  1; MemAluOut  in  XLEN  MEM-stage forward source
WbRd  in  RA_W; WbRegWrite  in  1; WbData  in  XLEN  WB-stage forward source
Operand1 / Operand2  out  XLEN  ALU operands
AluContrl  out  ALUC_W  ALU operation
StoreDataE  out  XLEN  forwarded rs2 for stores
ex_valid, RdE, RegWriteE, MemToRegE, MemWriteE, PCE  out  registered EX fields
id_stall  out  1  load-use hazard; upstream must hold PC and IF/ID

Behaviour:
- Reset (async, rst_n=0): ex_valid=0, all registered fields 0, AluContrl=ADD code; Operand1/Operand2/StoreDataE then evaluate to 0 (forward sources have rd=0). id_stall=0.
- Register update priority on each rising edge: ex_stall → hold all; else flush → bubble; else id_stall → bubble; else load decode fields with ex_valid=id_valid.
- Bubble: ex_valid=0, RegWriteE=MemToRegE=MemWriteE=0, RdE=0, AluContrl=ADD, operand sources cleared.
- Latency: one cycle ID→EX; forwarding is combinational within EX.
- Forwarding per source rsX (registered Rs1E/Rs2E): if rsX≠0 and MemRegWrite and MemRd==rsX → MemAluOut; else if rsX≠0 and WbRegWrite and WbRd==rsX → WbData; else registered read data. MEM beats WB. x0 is never forwarded; it always reads 0.
- Operand1 = AluSrc1E ? PCE : fwd_rs1. Operand2 per AluSrc2E: fwd_rs2 / ImmE / 32'd4 / ImmE. StoreDataE = fwd_rs2 always.
- Load-use: id_stall = ex_valid & MemToRegE & RdE≠0 & id_valid & (RdE==Rs1 | RdE==Rs2), masked to 0 when flush=1 or ex_stall=1. Gives exactly one bubble; the load is then in MEM/WB and the dependent instruction forwards WbData.
- ex_stall with flush: hold wins; the branch stays in EX and flush re-asserts next cycle.
- Outputs are not registered again; the ALU sees them the same cycle.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined: adds outputs PerfBubbleCnt and PerfFlushCnt (32 bits each, reset 0, wrap at 2^32). PerfBubbleCnt increments on each edge that inserts a load-use bubble; PerfFlushCnt increments on each edge that inserts a flush bubble with id_valid=1. Neither increments while ex_stall=1.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-run (rst_n low for 3 cycles, async, between edges) → ex_valid=0 immediately, Operand1=Operand2=0, AluContrl=ADD.
- ADD x3,x1,x2 followed by SUB x4,x3,x1, x1=5, x2=7 → second instruction gets Operand1=12 via MemAluOut with no stall.
- Same rd in MEM and WB (MemAluOut=0x11, WbData=0x22, both rd=x6), EX reads x6 → Operand1=0x11. Repeat with rd=x0 → Operand1=RegReadData1.
- LW x5 then ADD x7,x5,x5 → id_stall=1 for one cycle and one bubble (ex_valid=0); next cycle Operand1=Operand2=WbData=0xDEAD_BEEF.
- ex_stall=1 for 4 cycles with flush pulsed and new decode data → EX fields unchanged; after release, flush applies and ex_valid=0.
- JAL at PC=0x100 (AluSrc1=1, AluSrc2=2) → Operand1=0x100, Operand2=4; with the macro defined, 3 flushes give PerfFlushCnt=3.
